// File: rtl/clken_pkg.sv
// Shared constants, helpers and the config request record for the
// multi-channel clock-enable divider.
package clken_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int CH_MAX_W  = 3;   // up to 8 channels
  localparam int DIV_MAX_W = 16;  // widest divisor the request record can carry

  // Reset divisors for the stock three-channel build: /1, /2, /3.
  localparam logic [3*DIV_W_DEF-1:0] DIV_DEFAULT_3CH = {8'd2, 8'd1, 8'd0};

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [CH_MAX_W-1:0]  ch;
    logic [DIV_MAX_W-1:0] div;
  } cfg_req_t;

endpackage

// File: rtl/clken_channel.sv
// One divider channel: wrap counter, terminal-count decode and the
// enable strobe / square-wave outputs.
module clken_channel
  import clken_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             zero,      // restart the period at the next edge
  input  logic             load,      // take load_div as the new divisor
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] rst_div,
  output logic             tc,
  output logic             ce,
  output logic             sq
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  assign tc = (cnt == div);
  assign ce = tc & ~reset;
  assign sq = (cnt <= (div >> 1)) & ~reset;

  // Counter wraps at terminal count; a load always lands on a period
  // boundary, so restarting at zero keeps the waveform clean.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt <= '0;
      div <= rst_div;
    end else begin
      if (load) div <= load_div;
      if (zero || tc) cnt <= '0;
      else            cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clken_divider_multi.sv
// Multi-channel clock-enable generator: per-channel dividers, a one-deep
// divisor update register applied on terminal count or sync, and a
// post-reset hold sequencer for downstream logic.
module clken_divider_multi
  import clken_pkg::*;
#(
  parameter int                          NUM_CH      = 3,
  parameter int                          DIV_W       = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0]     DIV_DEFAULT = DIV_DEFAULT_3CH,
  parameter int                          RST_HOLD    = 16,
  localparam int                         CH_W        = ch_w(NUM_CH)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              rst_out
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  cfg_req_t          req;
  logic              pending;
  logic              xfer, in_range, accept, apply;
  logic [NUM_CH-1:0] tc, hit;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  assign cfg_ready = ~pending & ~reset;
  assign xfer      = cfg_valid & cfg_ready;
  assign in_range  = (int'(cfg_ch) < NUM_CH);
  assign accept    = xfer & in_range;
  // Accept needs ~pending, so accept and apply never share an edge.
  assign apply     = pending & (tc[req.ch[CH_W-1:0]] | sync);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = apply & (req.ch == CH_MAX_W'(i));

    clken_channel #(.DIV_W(DIV_W)) u_ch (
      .clkin    (clkin),
      .reset    (reset),
      .zero     (sync | hit[i]),
      .load     (hit[i]),
      .load_div (req.div[DIV_W-1:0]),
      .rst_div  (DIV_DEFAULT[i*DIV_W +: DIV_W]),
      .tc       (tc[i]),
      .ce       (ce[i]),
      .sq       (sq[i])
    );
  end

  // Config register: latch in-range requests, flag out-of-range ones.
  always_ff @(posedge clkin) begin
    if (reset) begin
      pending <= 1'b0;
      req     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (apply) pending <= 1'b0;
      if (accept) begin
        pending <= 1'b1;
        req.ch  <= CH_MAX_W'(cfg_ch);
        req.div <= DIV_MAX_W'(cfg_div);
      end
      if (xfer && !in_range) cfg_err <= 1'b1;
    end
  end

  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD));
  assign rst_out   = reset | ~hold_done;

  // Saturating post-reset hold counter.
  always_ff @(posedge clkin) begin
    if (reset)           hold_cnt <= '0;
    else if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
  end

endmodule
